// File: rtl/soc_wr_arbiter.sv
// Write-path arbiter: round-robin AW grant with ID widening,
// W forwarded in grant order through an order FIFO, B routed by ID MSBs.
module soc_wr_arbiter #(
  parameter int NUM_MASTERS  = 5,
  parameter int M_ID_WIDTH   = 4,
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int W_FIFO_DEPTH = 4,
  localparam int IDX_W      = $clog2(NUM_MASTERS),
  localparam int S_ID_WIDTH = M_ID_WIDTH + IDX_W,
  localparam int SW         = DATA_WIDTH / 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_aw_valid_i,
  output logic [NUM_MASTERS-1:0]            m_aw_ready_o,
  input  logic [NUM_MASTERS*M_ID_WIDTH-1:0] m_aw_id_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_aw_addr_i,
  input  logic [NUM_MASTERS*8-1:0]          m_aw_len_i,
  input  logic [NUM_MASTERS-1:0]            m_w_valid_i,
  output logic [NUM_MASTERS-1:0]            m_w_ready_o,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_w_data_i,
  input  logic [NUM_MASTERS*SW-1:0]         m_w_strb_i,
  input  logic [NUM_MASTERS-1:0]            m_w_last_i,
  output logic [NUM_MASTERS-1:0]            m_b_valid_o,
  input  logic [NUM_MASTERS-1:0]            m_b_ready_i,
  output logic [M_ID_WIDTH-1:0]             m_b_id_o,
  output logic [1:0]                        m_b_resp_o,
  output logic                              s_aw_valid_o,
  input  logic                              s_aw_ready_i,
  output logic [S_ID_WIDTH-1:0]             s_aw_id_o,
  output logic [ADDR_WIDTH-1:0]             s_aw_addr_o,
  output logic [7:0]                        s_aw_len_o,
  output logic                              s_w_valid_o,
  input  logic                              s_w_ready_i,
  output logic [DATA_WIDTH-1:0]             s_w_data_o,
  output logic [SW-1:0]                     s_w_strb_o,
  output logic                              s_w_last_o,
  input  logic                              s_b_valid_i,
  output logic                              s_b_ready_o,
  input  logic [S_ID_WIDTH-1:0]             s_b_id_i,
  input  logic [1:0]                        s_b_resp_i,
  output logic                              b_decerr_o
);

  localparam int PW = (W_FIFO_DEPTH > 1) ? $clog2(W_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(W_FIFO_DEPTH + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state;
  logic [IDX_W-1:0]     rr;
  logic [IDX_W-1:0]     win;
  logic                 found;
  logic                 grant;
  logic [M_ID_WIDTH-1:0] sel_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]           sel_len;
  int                   j;

  logic [IDX_W-1:0]     mem [W_FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        cnt;
  logic                 push;
  logic                 pop;
  logic                 w_open;
  logic [IDX_W-1:0]     head;
  logic                 h_valid;
  logic [IDX_W-1:0]     aw_idx;

  logic [IDX_W-1:0]     b_idx;
  logic                 b_in_range;
  logic                 b_sel_ready;

  // Scan upward from the pointer with wrap at NUM_MASTERS
  always_comb begin
    found    = 1'b0;
    win      = '0;
    sel_id   = '0;
    sel_addr = '0;
    sel_len  = '0;
    j        = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      j = int'(rr) + i;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      if (!found && m_aw_valid_i[j]) begin
        found    = 1'b1;
        win      = IDX_W'(j);
        sel_id   = m_aw_id_i[j*M_ID_WIDTH +: M_ID_WIDTH];
        sel_addr = m_aw_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = m_aw_len_i[j*8 +: 8];
      end
    end
  end

  assign grant = !rst_i && (state == IDLE) && found
                 && (cnt < CW'(W_FIFO_DEPTH));

  always_comb begin
    m_aw_ready_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++)
      m_aw_ready_o[k] = grant && (win == IDX_W'(k));
  end

  assign aw_idx = s_aw_id_o[S_ID_WIDTH-1 -: IDX_W];
  assign push   = (state == HOLD) && s_aw_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      rr           <= '0;
      s_aw_valid_o <= 1'b0;
      s_aw_id_o    <= '0;
      s_aw_addr_o  <= '0;
      s_aw_len_o   <= '0;
    end else begin
      unique case (state)
        IDLE: if (grant) begin
          state        <= HOLD;
          s_aw_valid_o <= 1'b1;
          s_aw_id_o    <= {win, sel_id};
          s_aw_addr_o  <= sel_addr;
          s_aw_len_o   <= sel_len;
        end
        HOLD: if (s_aw_ready_i) begin
          state        <= IDLE;
          s_aw_valid_o <= 1'b0;
          rr <= (aw_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : aw_idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= aw_idx;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PW'(W_FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == PW'(W_FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop) cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  assign head   = mem[rd_ptr];
  assign w_open = !rst_i && (cnt != '0);

  always_comb begin
    h_valid     = 1'b0;
    s_w_data_o  = '0;
    s_w_strb_o  = '0;
    s_w_last_o  = 1'b0;
    m_w_ready_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (head == IDX_W'(k)) begin
        h_valid        = m_w_valid_i[k];
        s_w_data_o     = m_w_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        s_w_strb_o     = m_w_strb_i[k*SW +: SW];
        s_w_last_o     = m_w_last_i[k];
        m_w_ready_o[k] = w_open && s_w_ready_i;
      end
    end
  end

  assign s_w_valid_o = w_open && h_valid;
  assign pop         = s_w_valid_o && s_w_ready_i && s_w_last_o;

  // Index values beyond NUM_MASTERS are sunk so the slave never stalls
  assign b_idx      = s_b_id_i[S_ID_WIDTH-1 -: IDX_W];
  assign b_in_range = {1'b0, b_idx} < (IDX_W + 1)'(NUM_MASTERS);
  assign m_b_id_o   = s_b_id_i[M_ID_WIDTH-1:0];
  assign m_b_resp_o = s_b_resp_i;

  always_comb begin
    m_b_valid_o = '0;
    b_sel_ready = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (b_idx == IDX_W'(k)) begin
        m_b_valid_o[k] = !rst_i && s_b_valid_i;
        b_sel_ready    = m_b_ready_i[k];
      end
    end
  end

  assign s_b_ready_o = !rst_i && (b_in_range ? b_sel_ready : 1'b1);
  assign b_decerr_o  = !rst_i && !b_in_range && s_b_valid_i;

endmodule

// File: tb/tb_soc_wr_arbiter.sv
// Directed bench for soc_wr_arbiter: AW round-robin, FIFO full,
// W ordering/stall, early W, HOLD stability, reset mid-burst, B routing.
module tb_soc_wr_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   aw_valid;
  wire  [4:0]   aw_ready;
  logic [19:0]  aw_id;
  logic [319:0] aw_addr;
  logic [39:0]  aw_len;
  logic [4:0]   w_valid;
  wire  [4:0]   w_ready;
  logic [319:0] w_data;
  logic [39:0]  w_strb;
  logic [4:0]   w_last;
  wire  [4:0]   b_valid;
  logic [4:0]   b_ready;
  wire  [3:0]   b_id;
  wire  [1:0]   b_resp;
  wire          s_aw_valid;
  logic         s_aw_ready;
  wire  [6:0]   s_aw_id;
  wire  [63:0]  s_aw_addr;
  wire  [7:0]   s_aw_len;
  wire          s_w_valid;
  logic         s_w_ready;
  wire  [63:0]  s_w_data;
  wire  [7:0]   s_w_strb;
  wire          s_w_last;
  logic         s_b_valid;
  wire          s_b_ready;
  logic [6:0]   s_b_id;
  logic [1:0]   s_b_resp;
  wire          b_decerr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  soc_wr_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .m_aw_valid_i(aw_valid), .m_aw_ready_o(aw_ready),
    .m_aw_id_i(aw_id), .m_aw_addr_i(aw_addr), .m_aw_len_i(aw_len),
    .m_w_valid_i(w_valid), .m_w_ready_o(w_ready),
    .m_w_data_i(w_data), .m_w_strb_i(w_strb), .m_w_last_i(w_last),
    .m_b_valid_o(b_valid), .m_b_ready_i(b_ready),
    .m_b_id_o(b_id), .m_b_resp_o(b_resp),
    .s_aw_valid_o(s_aw_valid), .s_aw_ready_i(s_aw_ready),
    .s_aw_id_o(s_aw_id), .s_aw_addr_o(s_aw_addr), .s_aw_len_o(s_aw_len),
    .s_w_valid_o(s_w_valid), .s_w_ready_i(s_w_ready),
    .s_w_data_o(s_w_data), .s_w_strb_o(s_w_strb), .s_w_last_o(s_w_last),
    .s_b_valid_i(s_b_valid), .s_b_ready_o(s_b_ready),
    .s_b_id_i(s_b_id), .s_b_resp_i(s_b_resp),
    .b_decerr_o(b_decerr)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic set_aw(input int k, input logic [3:0] id,
                        input logic [63:0] a, input logic [7:0] l);
    aw_id[k*4 +: 4]     = id;
    aw_addr[k*64 +: 64] = a;
    aw_len[k*8 +: 8]    = l;
  endtask

  task automatic set_w(input int k, input logic v, input logic [63:0] d,
                       input logic l);
    w_valid[k]         = v;
    w_data[k*64 +: 64] = d;
    w_strb[k*8 +: 8]   = 8'hF0 | 8'(k);
    w_last[k]          = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] base;
    base = 64'h4000_0000;
    rst = 1'b1;
    aw_valid = '0; aw_id = '0; aw_addr = '0; aw_len = '0;
    w_valid = '0; w_data = '0; w_strb = '0; w_last = '0;
    b_ready = '0; s_aw_ready = 1'b1; s_w_ready = 1'b1;
    s_b_valid = 1'b0; s_b_id = '0; s_b_resp = '0;
    for (int k = 0; k < 5; k++) set_aw(k, 4'(k), base + 64'(k * 256), 8'd0);
    aw_valid = 5'h1F;

    tick; tick; smp;
    check("rst_aw_ready", 64'(aw_ready), 0);
    check("rst_s_aw_valid", 64'(s_aw_valid), 0);
    check("rst_s_aw_id", 64'(s_aw_id), 0);
    check("rst_s_w_valid", 64'(s_w_valid), 0);
    check("rst_decerr", 64'(b_decerr), 0);

    tick; rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      smp;
      check("aw_grant", 64'(aw_ready), 64'(5'b1 << g));
      tick; aw_valid[g] = 1'b0;
      smp;
      check("aw_hold_valid", 64'(s_aw_valid), 1);
      check("aw_id", 64'(s_aw_id), 64'(g * 16 + g));
      check("aw_addr", s_aw_addr, base + 64'(g * 256));
      tick;
    end
    for (int i = 0; i < 3; i++) begin
      smp;
      check("aw_fifo_full", 64'(aw_ready), 0);
      tick;
    end

    set_w(0, 1'b1, 64'hA0, 1'b1);
    smp;
    check("w0_valid", 64'(s_w_valid), 1);
    check("w0_data", s_w_data, 64'hA0);
    check("w0_ready", 64'(w_ready), 64'(5'b00001));
    check("w0_still_full", 64'(aw_ready), 0);
    tick; set_w(0, 1'b0, 64'h0, 1'b0);
    smp;
    check("aw4_after_pop", 64'(aw_ready), 64'(5'b10000));
    tick; aw_valid[4] = 1'b0;
    smp;
    check("aw4_id", 64'(s_aw_id), 64'h44);
    tick;

    set_w(2, 1'b1, 64'h2000, 1'b0);
    smp;
    check("w2_nonhead_valid", 64'(s_w_valid), 0);
    check("w_ready_head1", 64'(w_ready), 64'(5'b00010));
    tick; set_w(1, 1'b1, 64'h1111, 1'b1);
    smp;
    check("w1_valid", 64'(s_w_valid), 1);
    check("w1_data", s_w_data, 64'h1111);
    tick;
    set_w(1, 1'b0, 64'h0, 1'b0);
    set_w(0, 1'b1, 64'hBAD, 1'b0);
    s_w_ready = 1'b0;
    smp;
    check("w2_stall_valid", 64'(s_w_valid), 1);
    check("w2_stall_ready", 64'(w_ready), 0);
    tick; s_w_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      set_w(2, 1'b1, 64'h2000 + 64'(b), b == 3);
      smp;
      check("w2_valid", 64'(s_w_valid), 1);
      check("w2_data", s_w_data, 64'h2000 + 64'(b));
      check("w2_strb", 64'(s_w_strb), 64'hF2);
      check("w2_last", 64'(s_w_last), 64'(b == 3));
      check("w2_ready_only", 64'(w_ready), 64'(5'b00100));
      tick;
    end
    set_w(2, 1'b0, 64'h0, 1'b0);
    for (int k = 3; k < 5; k++) begin
      set_w(k, 1'b1, 64'h3000 + 64'(k), 1'b1);
      smp;
      check("drain_data", s_w_data, 64'h3000 + 64'(k));
      check("drain_valid", 64'(s_w_valid), 1);
      tick; set_w(k, 1'b0, 64'h0, 1'b0);
    end
    smp;
    check("w_empty_valid", 64'(s_w_valid), 0);
    check("w_empty_ready", 64'(w_ready), 0);
    set_w(0, 1'b0, 64'h0, 1'b0);

    set_w(1, 1'b1, 64'h1B, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick; smp;
      check("early_w_blocked", 64'(s_w_valid), 0);
    end
    tick; s_aw_ready = 1'b0; aw_valid[1] = 1'b1;
    smp;
    check("aw1_grant", 64'(aw_ready), 64'(5'b00010));
    tick;
    aw_valid[1] = 1'b0; aw_valid[0] = 1'b1; aw_valid[3] = 1'b1;
    set_aw(1, 4'h5, 64'hDEAD, 8'h7);
    for (int i = 0; i < 5; i++) begin
      smp;
      check("hold_valid", 64'(s_aw_valid), 1);
      check("hold_id", 64'(s_aw_id), 64'h11);
      check("hold_addr", s_aw_addr, base + 64'h100);
      check("hold_len", 64'(s_aw_len), 0);
      check("hold_no_ready", 64'(aw_ready), 0);
      check("hold_w_blocked", 64'(s_w_valid), 0);
      tick;
    end
    s_aw_ready = 1'b1;
    smp;
    check("hs_w_blocked", 64'(s_w_valid), 0);
    tick;
    smp;
    check("w_after_aw", 64'(s_w_valid), 1);
    check("w_after_aw_data", s_w_data, 64'h1B);
    check("rr_after_hs", 64'(aw_ready), 64'(5'b01000));
    tick; set_w(1, 1'b0, 64'h0, 1'b0); aw_valid[3] = 1'b0;
    smp;
    check("aw3_id", 64'(s_aw_id), 64'h33);
    check("w_popped", 64'(s_w_valid), 0);
    tick;
    smp;
    check("rr_wrap", 64'(aw_ready), 64'(5'b00001));
    tick; aw_valid[0] = 1'b0;
    smp;
    check("aw0_valid", 64'(s_aw_valid), 1);
    tick;

    set_w(3, 1'b1, 64'h30, 1'b0);
    smp;
    check("rb_beat0", s_w_data, 64'h30);
    tick; set_w(3, 1'b1, 64'h31, 1'b0);
    smp;
    check("rb_beat1", s_w_data, 64'h31);
    tick; set_w(3, 1'b1, 64'h32, 1'b0); rst = 1'b1; aw_valid[4] = 1'b1;
    smp;
    check("rst_w_gate", 64'(s_w_valid), 0);
    tick; rst = 1'b0;
    smp;
    check("post_rst_w_valid", 64'(s_w_valid), 0);
    check("post_rst_w_ready", 64'(w_ready), 0);
    check("post_rst_aw_valid", 64'(s_aw_valid), 0);
    check("post_rst_grant4", 64'(aw_ready), 64'(5'b10000));
    tick; aw_valid[4] = 1'b0; set_w(3, 1'b0, 64'h0, 1'b0);
    smp;
    check("post_rst_aw4_id", 64'(s_aw_id), 64'h44);
    tick;

    s_b_valid = 1'b1; s_b_id = 7'h3A; s_b_resp = 2'b10; b_ready = 5'b01000;
    smp;
    check("b3_valid", 64'(b_valid), 64'(5'b01000));
    check("b3_id", 64'(b_id), 64'hA);
    check("b3_resp", 64'(b_resp), 64'h2);
    check("b3_sready", 64'(s_b_ready), 1);
    check("b3_decerr", 64'(b_decerr), 0);
    tick; b_ready = 5'b00000;
    smp;
    check("b3_backpressure", 64'(s_b_ready), 0);
    tick; s_b_id = 7'h47; b_ready = 5'b10000;
    smp;
    check("b4_valid", 64'(b_valid), 64'(5'b10000));
    check("b4_id", 64'(b_id), 64'h7);
    check("b4_sready", 64'(s_b_ready), 1);
    tick; s_b_id = 7'h65; b_ready = 5'b00000;
    smp;
    check("b6_valid", 64'(b_valid), 0);
    check("b6_sready", 64'(s_b_ready), 1);
    check("b6_decerr", 64'(b_decerr), 1);
    tick; s_b_id = 7'h5F;
    smp;
    check("b5_decerr", 64'(b_decerr), 1);
    check("b5_valid", 64'(b_valid), 0);
    tick; s_b_valid = 1'b0;
    smp;
    check("b_idle_decerr", 64'(b_decerr), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
